// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Sole master of the byte-wide single-port system RAM. It arbitrates between
//   instruction-cache word fetches and load/store-buffer accesses, and it breaks
//   each 1-, 2- or 4-byte request into consecutive byte cycles on the RAM port.
//
// Ports
//   clk_i, rst_i          clock; synchronous active-high reset
//   rdy_i                 CPU ready. When low, the block pauses and mem_wr_o is forced to 0
//   flush_i               misprediction flush. It aborts reads; stores are unaffected
//   ic_req_i/ic_addr_i    IC word fetch request (level) and word address
//   ic_done_o/ic_data_o   one-cycle completion pulse and the little-endian word
//   ls_req_i/ls_we_i      LSB request (level) and store flag
//   ls_addr_i/ls_size_i   byte address and size (00 byte, 01 half, 1x word)
//   ls_wdata_i            store data; the low bytes are used
//   ls_done_o/ls_rdata_o  one-cycle completion pulse and zero-extended load data
//   mem_a_o/mem_dout_o    registered RAM byte address and write byte
//   mem_wr_o              RAM write enable, gated by rdy_i
//   mem_din_i             RAM read byte, one cycle behind the sampled address
//   io_buffer_full_i      IO write buffer full; blocks stores to the IO region
module mem_arbiter #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_REGION  = 2'b11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rdy_i,
    input  logic                  flush_i,
    input  logic                  ic_req_i,
    input  logic [ADDR_WIDTH-1:0] ic_addr_i,
    output logic                  ic_done_o,
    output logic [31:0]           ic_data_o,
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [ADDR_WIDTH-1:0] ls_addr_i,
    input  logic [1:0]            ls_size_i,
    input  logic [31:0]           ls_wdata_i,
    output logic                  ls_done_o,
    output logic [31:0]           ls_rdata_o,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic [7:0]            mem_dout_o,
    output logic                  mem_wr_o,
    input  logic [7:0]            mem_din_i,
    input  logic                  io_buffer_full_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IC_RD = 2'd1;
    localparam logic [1:0] S_LS_RD = 2'd2;
    localparam logic [1:0] S_LS_WR = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;

    logic [1:0]            state_q,    state_d;
    logic [2:0]            cnt_q,      cnt_d;
    logic [2:0]            n_q,        n_d;       // byte count of the active request
    logic                  last_ls_q,  last_ls_d; // 1 = LS held the last grant
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;    // base address, kept for read restart
    logic [ADDR_WIDTH-1:0] mem_a_q,    mem_a_d;
    logic [7:0]            dout_q,     dout_d;
    logic [23:0]           wsh_q,      wsh_d;     // store bytes not yet presented
    logic                  wr_q,       wr_d;
    logic [31:0]           rd_buf_q,   rd_buf_d;
    logic                  stall_q,    stall_d;   // a read was paused by rdy_i low
    logic                  ic_done_q,  ic_done_d;
    logic                  ls_done_q,  ls_done_d;
    logic [31:0]           ic_data_q,  ic_data_d;
    logic [31:0]           ls_rdata_q, ls_rdata_d;

    logic       ic_elig, ls_elig, ls_io, gnt_ic, gnt_ls;
    logic [2:0] ls_n;

    assign ls_io   = (ls_addr_i[17:16] == IO_REGION);
    assign ic_elig = ic_req_i && !flush_i;
    // A store stays eligible under flush. A store to IO waits while the IO buffer is full.
    assign ls_elig = ls_req_i && (ls_we_i ? !(ls_io && io_buffer_full_i) : !flush_i);

    always_comb begin
        case (ls_size_i)
            2'b00:   ls_n = 3'd1;
            2'b01:   ls_n = 3'd2;
            default: ls_n = 3'd4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        last_ls_d  = last_ls_q;
        addr_d     = addr_q;
        mem_a_d    = mem_a_q;
        dout_d     = dout_q;
        wsh_d      = wsh_q;
        wr_d       = wr_q;
        rd_buf_d   = rd_buf_q;
        stall_d    = stall_q;
        ic_data_d  = ic_data_q;
        ls_rdata_d = ls_rdata_q;
        // Done pulses drop on every edge, even during a pause, so each one lasts exactly one cycle.
        ic_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        gnt_ic     = 1'b0;
        gnt_ls     = 1'b0;

        if (rdy_i) begin
            case (state_q)
                S_IDLE: begin
                    // Turnaround: no grant in the cycle a done pulse is visible.
                    if (!ic_done_q && !ls_done_q) begin
                        gnt_ic = ic_elig && (!ls_elig || last_ls_q);
                        gnt_ls = ls_elig && !gnt_ic;
                        if (gnt_ic) begin
                            state_d   = S_IC_RD;
                            last_ls_d = 1'b0;
                            addr_d    = ic_addr_i;
                            mem_a_d   = ic_addr_i;
                            cnt_d     = 3'd0;
                            n_d       = 3'd4;
                            rd_buf_d  = 32'h0;
                            stall_d   = 1'b0;
                        end else if (gnt_ls) begin
                            last_ls_d = 1'b1;
                            addr_d    = ls_addr_i;
                            mem_a_d   = ls_addr_i;
                            cnt_d     = 3'd0;
                            n_d       = ls_n;
                            stall_d   = 1'b0;
                            if (ls_we_i) begin
                                state_d = S_LS_WR;
                                dout_d  = ls_wdata_i[7:0];
                                wsh_d   = ls_wdata_i[31:8];
                                wr_d    = 1'b1;
                            end else begin
                                state_d  = S_LS_RD;
                                rd_buf_d = 32'h0;
                            end
                        end
                    end
                end
                S_IC_RD, S_LS_RD: begin
                    // cnt_q counts edges since the grant, minus one. On edge j the
                    // block captures byte j-2 and presents address A+j.
                    if (flush_i) begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                        stall_d = 1'b0;
                    end else if (stall_q) begin
                        // The bytes in flight were lost during the pause, so the read restarts from the base address.
                        mem_a_d  = addr_q;
                        cnt_d    = 3'd0;
                        rd_buf_d = 32'h0;
                        stall_d  = 1'b0;
                    end else begin
                        case (cnt_q)
                            3'd1:    rd_buf_d[7:0]   = mem_din_i;
                            3'd2:    rd_buf_d[15:8]  = mem_din_i;
                            3'd3:    rd_buf_d[23:16] = mem_din_i;
                            3'd4:    rd_buf_d[31:24] = mem_din_i;
                            default: ;
                        endcase
                        if (cnt_q == n_q) begin
                            state_d = S_IDLE;
                            cnt_d   = 3'd0;
                            if (state_q == S_IC_RD) begin
                                ic_done_d = 1'b1;
                                ic_data_d = rd_buf_d;
                            end else begin
                                ls_done_d  = 1'b1;
                                ls_rdata_d = rd_buf_d;
                            end
                        end else begin
                            if (cnt_q + 3'd1 < n_q) mem_a_d = mem_a_q + A_ONE;
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                S_LS_WR: begin
                    // The byte shown before this edge has just been written.
                    if (cnt_q + 3'd1 == n_q) begin
                        wr_d      = 1'b0;
                        ls_done_d = 1'b1;
                        state_d   = S_IDLE;
                        cnt_d     = 3'd0;
                    end else begin
                        mem_a_d = mem_a_q + A_ONE;
                        dout_d  = wsh_q[7:0];
                        wsh_d   = {8'h00, wsh_q[23:8]};
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q == S_IC_RD || state_q == S_LS_RD) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            n_q        <= 3'd0;
            last_ls_q  <= 1'b1;
            addr_q     <= '0;
            mem_a_q    <= '0;
            dout_q     <= 8'h0;
            wsh_q      <= 24'h0;
            wr_q       <= 1'b0;
            rd_buf_q   <= 32'h0;
            stall_q    <= 1'b0;
            ic_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            ic_data_q  <= 32'h0;
            ls_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            last_ls_q  <= last_ls_d;
            addr_q     <= addr_d;
            mem_a_q    <= mem_a_d;
            dout_q     <= dout_d;
            wsh_q      <= wsh_d;
            wr_q       <= wr_d;
            rd_buf_q   <= rd_buf_d;
            stall_q    <= stall_d;
            ic_done_q  <= ic_done_d;
            ls_done_q  <= ls_done_d;
            ic_data_q  <= ic_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_a_o    = mem_a_q;
    assign mem_dout_o = dout_q;
    assign mem_wr_o   = wr_q && rdy_i;
    assign ic_done_o  = ic_done_q;
    assign ic_data_o  = ic_data_q;
    assign ls_done_o  = ls_done_q;
    assign ls_rdata_o = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A RAM model answers reads one cycle late and logs
// every write. Expected data is queued when a request is driven and is popped
// when the matching done pulse or write byte appears.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        ic_req, ic_done, ls_req, ls_we, ls_done, mem_wr, io_full;
    logic [31:0] ic_addr, ic_data, ls_addr, ls_wdata, ls_rdata, mem_a;
    logic [1:0]  ls_size;
    logic [7:0]  mem_dout, mem_din;

    logic [7:0]  ram [logic [31:0]];
    logic [39:0] wr_log [$];
    logic [39:0] exp_wr [$];
    logic [31:0] exp_ic [$];
    logic [31:0] exp_ls [$];
    logic        exp_who [$];
    logic [31:0] last_ic;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .IO_REGION(2'b11)) dut (
        .clk_i(clk), .rst_i(rst), .rdy_i(rdy), .flush_i(flush),
        .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_done_o(ic_done), .ic_data_o(ic_data),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_size_i(ls_size),
        .ls_wdata_i(ls_wdata), .ls_done_o(ls_done), .ls_rdata_o(ls_rdata),
        .mem_a_o(mem_a), .mem_dout_o(mem_dout), .mem_wr_o(mem_wr), .mem_din_i(mem_din),
        .io_buffer_full_i(io_full)
    );

    // RAM: the address sampled at edge t appears on mem_din after t. Writes are logged only.
    always @(posedge clk) begin
        if (mem_wr) wr_log.push_back({mem_a, mem_dout});
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    end

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
        ic_req = 1'b0; ic_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = '0; ls_size = 2'b00; ls_wdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ic_done !== 1'b0) begin n_mis++; $display("FAIL reset_ic_done got %b want 0", ic_done); end
        n_cmp++; if (ls_done !== 1'b0) begin n_mis++; $display("FAIL reset_ls_done got %b want 0", ls_done); end
        n_cmp++; if (mem_wr !== 1'b0) begin n_mis++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
        n_cmp++; if (mem_a !== 32'h0) begin n_mis++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
        n_cmp++; if (ic_data !== 32'h0 || ls_rdata !== 32'h0 || mem_dout !== 8'h0) begin
            n_mis++; $display("FAIL reset_data got %h/%h/%h want 0", ic_data, ls_rdata, mem_dout);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ic_fetch();
        logic [31:0] e;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        exp_ic.push_back(32'h0000_0513);
        ic_addr = 32'h100; ic_req = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                n_cmp++;
                if (mem_a !== 32'h100 + k) begin n_mis++; $display("FAIL ic_mem_a k=%0d got %h want %h", k, mem_a, 32'h100 + k); end
            end
            n_cmp++;
            if (ic_done !== (k == 5)) begin n_mis++; $display("FAIL ic_done_timing k=%0d got %b want %b", k, ic_done, (k == 5)); end
        end
        e = exp_ic.pop_front();
        n_cmp++; if (ic_data !== e) begin n_mis++; $display("FAIL ic_data got %h want %h", ic_data, e); end
        last_ic = e;
        ic_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (ic_done !== 1'b0) begin n_mis++; $display("FAIL ic_done_pulse got %b want 0", ic_done); end
    endtask

    task automatic test_ls_load();
        logic [31:0] t_addr [3] = '{32'h1002, 32'h1003, 32'h100};
        logic [1:0]  t_size [3] = '{2'b01, 2'b00, 2'b10};
        logic [31:0] t_exp  [3] = '{32'h0000_CDAB, 32'h0000_00CD, 32'h0000_0513};
        int          t_lat  [3] = '{3, 2, 5};
        logic [31:0] e;
        ram[32'h1002] = 8'hAB; ram[32'h1003] = 8'hCD;
        for (int i = 0; i < 3; i++) begin
            exp_ls.push_back(t_exp[i]);
            ls_addr = t_addr[i]; ls_size = t_size[i]; ls_we = 1'b0; ls_req = 1'b1;
            for (int k = 0; k <= t_lat[i]; k++) begin
                @(negedge clk);
                n_cmp++;
                if (ls_done !== (k == t_lat[i])) begin n_mis++; $display("FAIL ls_done_timing i=%0d k=%0d got %b", i, k, ls_done); end
            end
            e = exp_ls.pop_front();
            n_cmp++; if (ls_rdata !== e) begin n_mis++; $display("FAIL ls_rdata i=%0d got %h want %h", i, ls_rdata, e); end
            ls_req = 1'b0;
            @(negedge clk);
            n_cmp++; if (ls_done !== 1'b0) begin n_mis++; $display("FAIL ls_done_pulse i=%0d got %b want 0", i, ls_done); end
        end
    endtask

    task automatic test_arbitration();
        int          got = 0;
        logic        w;
        logic [31:0] e;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        ram[32'h200] = 8'h93; ram[32'h201] = 8'h00; ram[32'h202] = 8'h10; ram[32'h203] = 8'h00;
        exp_who.push_back(1'b0); exp_who.push_back(1'b1); exp_who.push_back(1'b0);
        exp_ic.push_back(32'h0010_0093); exp_ic.push_back(32'h0010_0093);
        exp_ls.push_back(32'h0000_00AB);
        ic_addr = 32'h200; ic_req = 1'b1;
        ls_addr = 32'h1002; ls_size = 2'b00; ls_we = 1'b0; ls_req = 1'b1;
        for (int c = 0; c < 60 && got < 3; c++) begin
            @(negedge clk);
            if (ic_done || ls_done) begin
                w = exp_who.pop_front();
                n_cmp++;
                if (ls_done !== w) begin n_mis++; $display("FAIL arb_order grant=%0d got ls=%b want ls=%b", got, ls_done, w); end
                if (ic_done) begin
                    e = exp_ic.pop_front();
                    n_cmp++; if (ic_data !== e) begin n_mis++; $display("FAIL arb_ic_data got %h want %h", ic_data, e); end
                end else begin
                    e = exp_ls.pop_front();
                    n_cmp++; if (ls_rdata !== e) begin n_mis++; $display("FAIL arb_ls_data got %h want %h", ls_rdata, e); end
                end
                got++;
                if (got == 3) begin ic_req = 1'b0; ls_req = 1'b0; end
            end
        end
        if (got < 3) begin n_cmp++; n_mis++; $display("FAIL arb_timeout got %0d grants want 3", got); end
        ic_req = 1'b0; ls_req = 1'b0;
        exp_who.delete(); exp_ic.delete(); exp_ls.delete();
        last_ic = 32'h0010_0093;
        @(negedge clk);
    endtask

    task automatic test_store(input logic [31:0] a, input logic [31:0] d, input int pause_at,
                              input logic hold_flush, input int want_lat, input string nm);
        int          lat = -1;
        logic [39:0] e, g;
        wr_log.delete();
        for (int b = 0; b < 4; b++) exp_wr.push_back({a + b, d[8*b +: 8]});
        flush = hold_flush;
        ls_addr = a; ls_wdata = d; ls_size = 2'b10; ls_we = 1'b1; ls_req = 1'b1;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            @(negedge clk);
            if (c == pause_at) rdy = 1'b0;
            if (pause_at >= 0 && (c == pause_at + 1 || c == pause_at + 2)) begin
                n_cmp++; if (mem_wr !== 1'b0) begin n_mis++; $display("FAIL %s wr_while_paused got %b want 0", nm, mem_wr); end
                if (c == pause_at + 2) rdy = 1'b1;
            end
            if (ls_done) begin
                lat = c;
                n_cmp++; if (wr_log.size() != 4) begin n_mis++; $display("FAIL %s bytes_at_done got %0d want 4", nm, wr_log.size()); end
            end
        end
        n_cmp++; if (lat != want_lat) begin n_mis++; $display("FAIL %s done_latency got %0d want %0d", nm, lat, want_lat); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            n_cmp++;
            if (wr_log.size() == 0) begin n_mis++; $display("FAIL %s write_missing want %h", nm, e); end
            else begin
                g = wr_log.pop_front();
                if (g !== e) begin n_mis++; $display("FAIL %s write got %h want %h", nm, g, e); end
            end
        end
        ls_req = 1'b0; flush = 1'b0; rdy = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_io_store();
        io_full = 1'b1;
        wr_log.delete();
        ls_addr = 32'h30000; ls_wdata = 32'hDEAD_BEEF; ls_size = 2'b10; ls_we = 1'b1; ls_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_wr !== 1'b0 || ls_done !== 1'b0) begin n_mis++; $display("FAIL io_block c=%0d wr=%b done=%b want 0/0", c, mem_wr, ls_done); end
        end
        io_full = 1'b0;
        test_store(32'h30000, 32'hDEAD_BEEF, -1, 1'b0, 4, "io_store");
    endtask

    task automatic test_flush_read();
        logic [31:0] e;
        ic_addr = 32'h100; ic_req = 1'b1;
        @(negedge clk);            // after grant edge
        @(negedge clk); flush = 1'b1;
        @(negedge clk);            // flush edge passed; should be IDLE
        flush = 1'b0; ic_req = 1'b0;
        exp_ls.push_back(32'h0000_00CD);
        ls_addr = 32'h1003; ls_size = 2'b00; ls_we = 1'b0; ls_req = 1'b1;
        for (int k = 3; k <= 7; k++) begin
            @(negedge clk);
            n_cmp++; if (ic_done !== 1'b0) begin n_mis++; $display("FAIL flush_no_ic_done k=%0d got %b want 0", k, ic_done); end
            n_cmp++; if (ls_done !== (k == 5)) begin n_mis++; $display("FAIL flush_idle_next k=%0d ls_done=%b want %b", k, ls_done, (k == 5)); end
            if (k == 5) begin
                e = exp_ls.pop_front();
                n_cmp++; if (ls_rdata !== e) begin n_mis++; $display("FAIL flush_ls_data got %h want %h", ls_rdata, e); end
                ls_req = 1'b0;
            end
        end
        n_cmp++; if (ic_data !== last_ic) begin n_mis++; $display("FAIL flush_ic_data_held got %h want %h", ic_data, last_ic); end
    endtask

    task automatic test_rdy_load();
        int          got = 0;
        logic [31:0] e;
        ram[32'h300] = 8'h44; ram[32'h301] = 8'h33; ram[32'h302] = 8'h22; ram[32'h303] = 8'h11;
        exp_ls.push_back(32'h1122_3344);
        ls_addr = 32'h300; ls_size = 2'b10; ls_we = 1'b0; ls_req = 1'b1;
        @(negedge clk); @(negedge clk);
        @(negedge clk); rdy = 1'b0;
        @(negedge clk);
        @(negedge clk); rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_a !== 32'h300) begin n_mis++; $display("FAIL rdy_load_restart mem_a got %h want 300", mem_a); end
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            if (ls_done) begin
                got = 1;
                e = exp_ls.pop_front();
                n_cmp++; if (ls_rdata !== e) begin n_mis++; $display("FAIL rdy_load_data got %h want %h", ls_rdata, e); end
            end
        end
        if (got == 0) begin n_cmp++; n_mis++; $display("FAIL rdy_load_timeout no ls_done"); end
        ls_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        int pulses = 0;
        ls_addr = 32'h2020; ls_wdata = 32'h5566_7788; ls_size = 2'b10; ls_we = 1'b1; ls_req = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_wr !== 1'b0 || ls_done !== 1'b0) begin n_mis++; $display("FAIL rst_mid wr=%b done=%b want 0/0", mem_wr, ls_done); end
        rst = 1'b0; ls_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ls_done || mem_wr) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_mis++; $display("FAIL rst_mid_activity got %0d want 0", pulses); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ic_fetch();
        test_ls_load();
        test_arbitration();
        test_io_store();
        test_flush_read();
        test_store(32'h2000, 32'h1122_3344, -1, 1'b1, 4, "flush_store");
        test_store(32'h2010, 32'hA1B2_C3D4, 1, 1'b0, 6, "rdy_store");
        test_rdy_load();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
